// File: rtl/mac_accumulate_if.sv
// Handshake bundle between the multiplier, the accumulate stage and its consumer.
// in_* side carries products; out_* side carries burst results.
interface mac_accumulate_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/mac_accumulate.sv
// Burst accumulator behind the shift-and-add multiplier.
// Define MAC_ACCUMULATE_SATURATE_EN to clamp the sum instead of wrapping.
module mac_accumulate #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input logic             clk,
  input logic             rst_n,
  input logic             clear,
  mac_accumulate_if.slave bus
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;

  assign bus.in_ready = (state_q == ACCUM) && !clear;
  assign accept       = bus.in_valid && bus.in_ready;

  assign sum = {1'b0, acc_q}
             + {{(ACC_W+1-DATA_W){1'b0}}, bus.in_product};
  assign carry = sum[ACC_W];

`ifdef MAC_ACCUMULATE_SATURATE_EN
  // Once clamped, any further nonzero term carries again.
  assign acc_next = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  assign cnt_next = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (bus.in_last) begin
              out_acc_d   = acc_next;
              out_count_d = cnt_next;
              out_ovf_d   = ovf_q | carry;
              out_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_d       = 1'b0;
              state_d     = HOLD;
            end else begin
              acc_d = acc_next;
              cnt_d = cnt_next;
              ovf_d = ovf_q | carry;
            end
          end
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accumulate.sv
// Scoreboard bench for mac_accumulate: directed scenarios plus random bursts.
// Expected results come from whole-burst arithmetic on the accepted terms.
module tb_mac_accumulate;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 40;
  localparam int CNT_W  = 8;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  mac_accumulate_if #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) bus ();

  mac_accumulate #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  logic [63:0] burst_sum = 0;
  int          burst_n   = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Reference: true sum of the burst, reduced once at the end.
  task automatic model_accept(input logic [31:0] p, input bit last);
    exp_t e;
    burst_sum += {32'd0, p};
    burst_n++;
    if (last) begin
      e.ovf = (burst_sum >= (64'd1 << ACC_W));
`ifdef MAC_ACCUMULATE_SATURATE_EN
      e.acc = e.ovf ? {ACC_W{1'b1}} : burst_sum[ACC_W-1:0];
`else
      e.acc = burst_sum[ACC_W-1:0];
`endif
      e.cnt = (burst_n > 255) ? 8'd255 : 8'(burst_n);
      exp_q.push_back(e);
      burst_sum = 0;
      burst_n   = 0;
    end
  endtask

  task automatic send(input logic [31:0] p, input bit last,
                      output int waits);
    waits = 0;
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    bus.in_last    = last;
    @(negedge clk);
    while (!bus.in_ready && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    model_accept(p, last);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && !clear && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(bus.out_acc), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_acc", 64'(bus.out_acc), 64'(e.acc));
        chk("sb_count", 64'(bus.out_count), 64'(e.cnt));
        chk("sb_ovf", 64'(bus.out_ovf), 64'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n          = 1'b0;
    clear          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_acc", 64'(bus.out_acc), 64'd0);
    chk("rst_out_count", 64'(bus.out_count), 64'd0);
    chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst, consumer ready.
    bus.out_ready = 1'b1;
    send(6, 0, t);
    send(15, 0, t);
    send(100, 1, t);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid", 64'(bus.out_valid), 64'd1);
    chk("basic_acc", 64'(bus.out_acc), 64'd121);
    chk("basic_count", 64'(bus.out_count), 64'd3);
    @(posedge clk);
    #1;

    // Same burst, then backpressure with beats pulsed at the stage.
    bus.out_ready = 1'b0;
    send(6, 0, t);
    send(15, 0, t);
    send(100, 1, t);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid   = (i % 2 == 0);
      bus.in_product = 32'd7;
      bus.in_last    = 1'b1;
      @(negedge clk);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_acc", 64'(bus.out_acc), 64'd121);
      chk("hold_count", 64'(bus.out_count), 64'd3);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(7, 1, t);
    chk("bp_accept_gap", 64'(t), 64'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_seven", 64'(bus.out_acc), 64'd7);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a burst.
    send(1, 0, t);
    send(2, 0, t);
    send(3, 0, t);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    burst_sum = 0;
    burst_n   = 0;
    exp_q.delete();
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_acc", 64'(bus.out_acc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(5, 1, t);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("arst_five_acc", 64'(bus.out_acc), 64'd5);
    chk("arst_five_cnt", 64'(bus.out_count), 64'd1);
    @(posedge clk);
    #1;

    // Clear collides with an output handshake.
    bus.out_ready = 1'b0;
    send(4, 1, t);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_held", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    clear = 1'b1;
    exp_q.delete();
    #1;
    chk("clr_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    #1;
    chk("clr_valid", 64'(bus.out_valid), 64'd0);
    chk("clr_accum", 64'(bus.in_ready), 64'd1);
    send(9, 1, t);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_nine", 64'(bus.out_acc), 64'd9);
    @(posedge clk);
    #1;

    // Back-to-back bursts with in_valid held high.
    send(1, 0, t);
    chk("b2b_first_gap", 64'(t), 64'd0);
    send(2, 1, t);
    chk("b2b_second_gap", 64'(t), 64'd0);
    send(3, 1, t);
    chk("b2b_burst_gap", 64'(t), 64'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_three", 64'(bus.out_acc), 64'd3);
    @(posedge clk);
    #1;

    // 257 max-value terms: wrap (or clamp) and count saturation.
    for (int i = 0; i < 257; i++) send(32'hFFFF_FFFF, i == 256, t);
    bus.in_valid = 1'b0;
    @(negedge clk);
`ifdef MAC_ACCUMULATE_SATURATE_EN
    chk("ovf_acc", 64'(bus.out_acc), 64'hFF_FFFF_FFFF);
`else
    chk("ovf_acc", 64'(bus.out_acc), 64'h00_FFFF_FEFF);
`endif
    chk("ovf_count", 64'(bus.out_count), 64'd255);
    chk("ovf_flag", 64'(bus.out_ovf), 64'd1);
    @(posedge clk);
    #1;

    // Random bursts with idle gaps.
    for (int b = 0; b < 25; b++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        send($urandom, k == len - 1, t);
        if ($urandom_range(0, 2) == 0) begin
          bus.in_valid = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    end
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_accumulate.md
Name: mac_accumulate

Overview:
- Sequential accumulate stage directly downstream of the 32-bit shift-and-add multiplier.
- Consumes the multiplier's unsigned 32-bit Product through a valid/ready handshake.
- Sums products into a widened accumulator over a burst terminated by in_last.
- Presents the sum, term count and overflow flag to the next stage through a second valid/ready handshake.

Parameters:
- DATA_W, 32: width of incoming product (matches multiplier Product width).
- ACC_W, 40: accumulator width; must be >= DATA_W.
- CNT_W, 8: width of the term counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of the burst in progress and any held result.
- in_valid  input  1  upstream product valid.
- in_ready  output  1  stage can accept a product this cycle.
- in_product  input  DATA_W  unsigned product from the multiplier.
- in_last  input  1  qualifies the accepted beat as the final term of the burst.
- out_valid  output  1  result held and valid.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  accumulated sum of the burst.
- out_count  output  CNT_W  number of terms in the burst.
- out_ovf  output  1  sticky overflow flag for the burst.

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous, active-low.
  - While rst_n=0: state=ACCUM, internal acc/cnt/ovf=0, out_valid=0, out_acc=0, out_count=0, out_ovf=0.
  - Assertion mid-burst discards all partial state immediately, without waiting for a clock edge.
- States: ACCUM and HOLD.
- in_ready = (state==ACCUM) && !clear. Combinational; does not depend on in_valid.
- Accept event: in_valid && in_ready at a rising edge.
- ACCUM, accept with in_last=0:
  - acc <= acc + zero-extended in_product, modulo 2^ACC_W.
  - cnt <= cnt+1, saturating at 2^CNT_W-1.
  - ovf |= carry out of bit ACC_W-1.
- ACCUM, accept with in_last=1:
  - out_acc <= acc + in_product; out_count <= cnt+1 (saturating); out_ovf <= ovf | carry.
  - out_valid <= 1; internal acc/cnt/ovf <= 0; next state HOLD.
  - Latency: out_valid rises the cycle after the last beat is accepted.
- Burst of one term: a single beat with in_last=1 produces out_acc=in_product, out_count=1.
- HOLD:
  - in_ready=0; out_acc, out_count and out_ovf stable.
  - out_valid stays 1 until out_valid && out_ready at an edge; then out_valid <= 0 and state <= ACCUM.
  - No same-cycle bypass. Minimum spacing: one result per N+1 cycles for an N-term burst.
- clear:
  - Highest priority after reset. At the edge: acc/cnt/ovf=0, out_valid=0, state=ACCUM.
  - Any beat presented in the same cycle is not accepted (in_ready already low).
  - A held result is dropped even if out_ready=1 in that cycle.
  - out_acc, out_count and out_ovf retain their last values but are meaningless while out_valid=0.
- in_valid=0 in ACCUM: all state holds. No timeout.
- Arithmetic is unsigned throughout. No sign extension, because the multiplier delivers the low 32 bits of an unsigned product.

Optional Feature:
- Macro: MAC_ACCUMULATE_SATURATE_EN.
- Defined: on carry out, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the burst. Overflow flagging is unchanged (out_ovf=1).
- Undefined: acc wraps modulo 2^ACC_W. out_ovf still records the carry.

Test Plan:
- Reset mid-burst:
  - Stimulus: accept 3 beats, assert rst_n=0 between edges.
  - Required: out_valid=0 and in_ready=1 immediately.
  - Then a burst {5 last} → out_acc=5, out_count=1.
- Basic burst with backpressure:
  - Stimulus: products 6, 15, 100 (last) with out_ready=1.
  - Required: out_valid one cycle after the third accept; out_acc=121, out_count=3, out_ovf=0.
  - Stimulus: hold out_ready=0 for 4 cycles, pulsing in_valid with product 7.
  - Required: in_ready=0, outputs stable, no beat consumed; product 7 accepted only after the output handshake.
- Overflow, ACC_W=40:
  - Stimulus: 257 beats of 0xFFFFFFFF, last on beat 257.
  - Required without macro: out_acc=(257*(2^32-1)) mod 2^40 = 0x00FFFFFEFF, out_ovf=1, out_count=255 (saturated, CNT_W=8).
  - Required with macro: out_acc=0xFFFFFFFFFF, out_ovf=1.
- Clear collision:
  - Stimulus: in HOLD with out_ready=1, assert clear in the same cycle.
  - Required: next cycle out_valid=0, state ACCUM.
  - Stimulus: next burst {9 last}.
  - Required: out_acc=9 (no carry-over).
- Back-to-back bursts:
  - Stimulus: {1,2 last} then {3 last} with in_valid held high and out_ready=1.
  - Required: results 3 then 3, with a one-cycle in_ready=0 gap between bursts; no beat lost or duplicated.
